// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with an NPEND-entry scoreboard for in-flight long-latency writes.
// Optional stall statistics counters are compiled in when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
   parameter int REG_AW = 5,
   parameter int NPEND  = 4,
   parameter int TAGW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic              useaD,
   input  logic              usebD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic              memtoregE,
   input  logic [REG_AW-1:0] writeregM,
   input  logic              regwriteM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteW,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_wreg,
   output logic              iss_ready,
   output logic [TAGW-1:0]   iss_tag,
   input  logic              cmp_valid,
   input  logic [TAGW-1:0]   cmp_tag,
   input  logic              flush_all,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              flushE,
`ifdef HAZARD_STATS_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       sb_stall_cycles,
   output logic [31:0]       full_stall_cycles,
`endif
   output logic [TAGW:0]     sb_count
);

   logic [NPEND-1:0]  valid_q;
   logic [NPEND-1:0]  valid_d;
   logic [REG_AW-1:0] wreg_q [NPEND];
   logic [TAGW:0]     count_q;
   logic [TAGW:0]     count_d;

   logic [TAGW-1:0]   free_tag;
   logic              full;
   logic              accept;
   logic              cmp_hit;
   logic              busy_a;
   logic              busy_b;
   logic              sbstall;
   logic              lwstall;
   logic              fullstall;

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] wm, input logic wem,
                                          input logic [REG_AW-1:0] ww, input logic wew);
      logic [1:0] sel;
      sel = 2'b00;
      if (src == '0)
         sel = 2'b00;
      else if (wem && src == wm)
         sel = 2'b10;
      else if (wew && src == ww)
         sel = 2'b01;
      return sel;
   endfunction

   // Lowest free index wins: scan high to low so the last hit is the lowest.
   always_comb begin
      free_tag = '0;
      for (int i = NPEND - 1; i >= 0; i--) begin
         if (!valid_q[i])
            free_tag = TAGW'(i);
      end
   end

   assign full      = (count_q == (TAGW+1)'(NPEND));
   assign accept    = iss_valid & ~full & ~flush_all;
   assign fullstall = iss_valid & full;

   always_comb begin
      cmp_hit = 1'b0;
      busy_a  = 1'b0;
      busy_b  = 1'b0;
      for (int i = 0; i < NPEND; i++) begin
         if (cmp_valid && cmp_tag == TAGW'(i) && valid_q[i])
            cmp_hit = 1'b1;
         if (valid_q[i] && wreg_q[i] == rsD)
            busy_a = 1'b1;
         if (valid_q[i] && wreg_q[i] == rtD)
            busy_b = 1'b1;
      end
      if (rsD == '0)
         busy_a = 1'b0;
      if (rtD == '0)
         busy_b = 1'b0;
   end

   assign sbstall = (useaD & busy_a) | (usebD & busy_b);
   assign lwstall = memtoregE & (writeregE != '0) &
                    ((useaD & (writeregE == rsD)) | (usebD & (writeregE == rtD)));

   // The allocated tag is free in registered state, so it can never collide with a completing tag.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < NPEND; i++) begin
         if (cmp_valid && cmp_tag == TAGW'(i))
            valid_d[i] = 1'b0;
         if (accept && free_tag == TAGW'(i))
            valid_d[i] = 1'b1;
      end
      count_d = count_q;
      if (accept && !cmp_hit)
         count_d = count_q + 1'b1;
      else if (!accept && cmp_hit)
         count_d = count_q - 1'b1;
      if (flush_all) begin
         valid_d = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         if (accept)
            wreg_q[free_tag] <= iss_wreg;
      end
   end

   always_comb begin
      iss_ready = 1'b1;
      iss_tag   = '0;
      sb_count  = '0;
      forwardaE = 2'b00;
      forwardbE = 2'b00;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushE    = 1'b0;
      if (!rst) begin
         iss_ready = ~full;
         iss_tag   = free_tag;
         sb_count  = count_q;
         forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
         forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
         if (flush_all) begin
            flushE = 1'b1;
         end else if (fullstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
         end else if (sbstall || lwstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic sb_cause;
   assign sb_cause = ~flush_all & ~fullstall & sbstall;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles      <= '0;
         sb_stall_cycles   <= '0;
         full_stall_cycles <= '0;
      end else begin
         if (stallD && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (sb_cause && sb_stall_cycles != '1)
            sb_stall_cycles <= sb_stall_cycles + 32'd1;
         if (fullstall && full_stall_cycles != '1)
            full_stall_cycles <= full_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for the combinational hazards,
// hand-written sequences for scoreboard issue/complete/flush/reset behaviour.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW, iss_wreg;
   logic       useaD, usebD, memtoregE, regwriteM, regwriteW;
   logic       iss_valid, cmp_valid, flush_all;
   logic [1:0] cmp_tag;
   logic       iss_ready;
   logic [1:0] iss_tag;
   logic [1:0] forwardaE, forwardbE;
   logic       stallF, stallD, stallE, flushE;
   logic [2:0] sb_count;

   int checks = 0;
   int errors = 0;

   hazard_scoreboard #(.REG_AW(5), .NPEND(4), .TAGW(2)) dut (
      .clk(clk), .rst(rst),
      .rsD(rsD), .rtD(rtD), .useaD(useaD), .usebD(usebD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .memtoregE(memtoregE),
      .writeregM(writeregM), .regwriteM(regwriteM),
      .writeregW(writeregW), .regwriteW(regwriteW),
      .iss_valid(iss_valid), .iss_wreg(iss_wreg), .iss_ready(iss_ready), .iss_tag(iss_tag),
      .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .flush_all(flush_all),
      .forwardaE(forwardaE), .forwardbE(forwardbE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
      .sb_count(sb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs_d, rt_d;
      logic       usea, useb;
      logic [4:0] rs_e, rt_e, wr_e;
      logic       mem_e;
      logic [4:0] wr_m;
      logic       rw_m;
      logic [4:0] wr_w;
      logic       rw_w;
      logic [1:0] exp_fa, exp_fb;
      logic       exp_sf, exp_sd, exp_se, exp_fe;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; useaD = 0; usebD = 0;
      rsE = 0; rtE = 0; writeregE = 0; memtoregE = 0;
      writeregM = 0; regwriteM = 0; writeregW = 0; regwriteW = 0;
      iss_valid = 0; iss_wreg = 0; cmp_valid = 0; cmp_tag = 0; flush_all = 0;
   endtask

   task automatic check_stalls(input string name, input logic sf, input logic sd,
                               input logic se, input logic fe);
      check({name, "_stallF"}, {31'd0, stallF}, {31'd0, sf});
      check({name, "_stallD"}, {31'd0, stallD}, {31'd0, sd});
      check({name, "_stallE"}, {31'd0, stallE}, {31'd0, se});
      check({name, "_flushE"}, {31'd0, flushE}, {31'd0, fe});
   endtask

   initial begin
      //          rsD rtD ua ub rsE rtE wrE mem wrM rwM wrW rwW  fa     fb     sF sD sE fE
      vecs[0]  = '{0,  8,  0, 1, 0,  0,  8,  1,  0,  0,  0,  0, 2'b00, 2'b00, 1, 1, 0, 1};
      vecs[1]  = '{0,  8,  0, 1, 0,  0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0, 0};
      vecs[2]  = '{0,  8,  0, 0, 0,  0,  8,  1,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0, 0};
      vecs[3]  = '{8,  0,  1, 0, 0,  0,  8,  1,  0,  0,  0,  0, 2'b00, 2'b00, 1, 1, 0, 1};
      vecs[4]  = '{8,  0,  1, 0, 0,  0,  8,  0,  0,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0, 0};
      vecs[5]  = '{0,  0,  0, 0, 7,  7,  0,  0,  7,  1,  7,  1, 2'b10, 2'b10, 0, 0, 0, 0};
      vecs[6]  = '{0,  0,  0, 0, 7,  7,  0,  0,  7,  0,  7,  1, 2'b01, 2'b01, 0, 0, 0, 0};
      vecs[7]  = '{0,  0,  0, 0, 0,  7,  0,  0,  7,  1,  7,  1, 2'b00, 2'b10, 0, 0, 0, 0};
      vecs[8]  = '{0,  0,  0, 0, 3,  4,  0,  0,  3,  1,  4,  1, 2'b10, 2'b01, 0, 0, 0, 0};
      vecs[9]  = '{0,  0,  0, 0, 5,  6,  0,  0,  3,  1,  4,  1, 2'b00, 2'b00, 0, 0, 0, 0};
      vecs[10] = '{0,  0,  0, 0, 9,  9,  0,  0,  0,  0,  9,  0, 2'b00, 2'b00, 0, 0, 0, 0};

      clear_inputs();
      rst = 1;
      step();
      step();
      // Reset held with hazard-provoking inputs: everything forced quiet.
      rsE = 3; writeregM = 3; regwriteM = 1;
      useaD = 1; rsD = 1; memtoregE = 1; writeregE = 1; iss_valid = 1;
      #1;
      check("rst_fwdA", {30'd0, forwardaE}, 32'd0);
      check("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
      check("rst_iss_tag", {30'd0, iss_tag}, 32'd0);
      check_stalls("rst_hold", 0, 0, 0, 0);
      clear_inputs();
      step();
      rst = 0;
      #1;
      check("reset_count", {29'd0, sb_count}, 32'd0);
      check("reset_ready", {31'd0, iss_ready}, 32'd1);

      for (int i = 0; i < 11; i++) begin
         rsD = vecs[i].rs_d; rtD = vecs[i].rt_d; useaD = vecs[i].usea; usebD = vecs[i].useb;
         rsE = vecs[i].rs_e; rtE = vecs[i].rt_e; writeregE = vecs[i].wr_e;
         memtoregE = vecs[i].mem_e; writeregM = vecs[i].wr_m; regwriteM = vecs[i].rw_m;
         writeregW = vecs[i].wr_w; regwriteW = vecs[i].rw_w;
         #2;
         check($sformatf("vec%0d_fwdA", i), {30'd0, forwardaE}, {30'd0, vecs[i].exp_fa});
         check($sformatf("vec%0d_fwdB", i), {30'd0, forwardbE}, {30'd0, vecs[i].exp_fb});
         check_stalls($sformatf("vec%0d", i), vecs[i].exp_sf, vecs[i].exp_sd,
                      vecs[i].exp_se, vecs[i].exp_fe);
      end
      clear_inputs();
      step();

      // Scoreboard stall on a pending div result.
      iss_valid = 1; iss_wreg = 5;
      #1;
      check("s1_iss_tag", {30'd0, iss_tag}, 32'd0);
      check_stalls("s1_issue", 0, 0, 0, 0);
      step();
      iss_valid = 0; useaD = 1; rsD = 5;
      #1;
      check("s1_count1", {29'd0, sb_count}, 32'd1);
      check_stalls("s1_busy", 1, 1, 0, 1);
      step();
      check_stalls("s1_busy2", 1, 1, 0, 1);
      cmp_valid = 1; cmp_tag = 0;
      #1;
      check_stalls("s1_cmp_cycle", 1, 1, 0, 1);
      step();
      cmp_valid = 0;
      #1;
      check_stalls("s1_released", 0, 0, 0, 0);
      check("s1_count0", {29'd0, sb_count}, 32'd0);

      // Register 0 never hazards even when pending.
      iss_valid = 1; iss_wreg = 0; useaD = 0;
      step();
      iss_valid = 0; useaD = 1; rsD = 0;
      #1;
      check("r0_count", {29'd0, sb_count}, 32'd1);
      check("r0_stallD", {31'd0, stallD}, 32'd0);
      cmp_valid = 1; cmp_tag = 0;
      step();
      clear_inputs();
      #1;
      check("r0_count0", {29'd0, sb_count}, 32'd0);

      // Fill all four entries, then back-pressure.
      for (int i = 0; i < 4; i++) begin
         iss_valid = 1; iss_wreg = 5'(i + 1);
         #1;
         check($sformatf("fill%0d_tag", i), {30'd0, iss_tag}, i);
         check($sformatf("fill%0d_ready", i), {31'd0, iss_ready}, 32'd1);
         step();
      end
      iss_wreg = 9; useaD = 1; rsD = 1;
      #1;
      check("full_count", {29'd0, sb_count}, 32'd4);
      check("full_ready", {31'd0, iss_ready}, 32'd0);
      check_stalls("full_stall", 1, 1, 1, 0);
      cmp_valid = 1; cmp_tag = 2;
      #1;
      check("full_cmp_ready", {31'd0, iss_ready}, 32'd0);
      step();
      cmp_valid = 0; useaD = 0;
      #1;
      check("freed_count", {29'd0, sb_count}, 32'd3);
      check("freed_ready", {31'd0, iss_ready}, 32'd1);
      check("freed_tag", {30'd0, iss_tag}, 32'd2);
      check_stalls("freed", 0, 0, 0, 0);
      step();
      iss_valid = 0; useaD = 1; rsD = 3;
      #1;
      check("refull_count", {29'd0, sb_count}, 32'd4);
      check("reg3_released", {31'd0, stallD}, 32'd0);
      useaD = 0;

      // Full with simultaneous completion and issue: issue waits one cycle.
      cmp_valid = 1; cmp_tag = 1; iss_valid = 1; iss_wreg = 4;
      #1;
      check("simul_ready", {31'd0, iss_ready}, 32'd0);
      check("simul_stallE", {31'd0, stallE}, 32'd1);
      step();
      cmp_valid = 0;
      #1;
      check("simul_count3", {29'd0, sb_count}, 32'd3);
      check("simul_tag", {30'd0, iss_tag}, 32'd1);
      check("simul_ready2", {31'd0, iss_ready}, 32'd1);
      check("simul_stallE2", {31'd0, stallE}, 32'd0);
      step();
      iss_valid = 0;
      #1;
      check("simul_count4", {29'd0, sb_count}, 32'd4);

      // WAW: tags 1 and 3 both target r4; completing one keeps r4 busy.
      cmp_valid = 1; cmp_tag = 3;
      step();
      cmp_valid = 0; useaD = 1; rsD = 4;
      #1;
      check("waw_count", {29'd0, sb_count}, 32'd3);
      check("waw_busy", {31'd0, stallD}, 32'd1);

      // Flush with three entries valid and a concurrent issue.
      flush_all = 1; iss_valid = 1; iss_wreg = 7;
      #1;
      check_stalls("flush", 0, 0, 0, 1);
      step();
      flush_all = 0; iss_valid = 0;
      #1;
      check("flush_count", {29'd0, sb_count}, 32'd0);
      check("flush_unbusy", {31'd0, stallD}, 32'd0);
      check("flush_tag", {30'd0, iss_tag}, 32'd0);
      cmp_valid = 1; cmp_tag = 1;
      step();
      cmp_valid = 0; useaD = 0;
      #1;
      check("stale_cmp_count", {29'd0, sb_count}, 32'd0);

      // Stale completion with live entries, then reset mid-operation.
      iss_valid = 1; iss_wreg = 10;
      step();
      iss_wreg = 11;
      step();
      iss_valid = 0; cmp_valid = 1; cmp_tag = 3;
      step();
      cmp_valid = 0;
      #1;
      check("invalid_cmp_count", {29'd0, sb_count}, 32'd2);
      rst = 1; useaD = 1; rsD = 10;
      #1;
      check("midrst_count", {29'd0, sb_count}, 32'd0);
      check("midrst_stallD", {31'd0, stallD}, 32'd0);
      check("midrst_ready", {31'd0, iss_ready}, 32'd1);
      step();
      rst = 0;
      #1;
      check("postrst_count", {29'd0, sb_count}, 32'd0);
      check("postrst_stallD", {31'd0, stallD}, 32'd0);
      check("postrst_tag", {30'd0, iss_tag}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the 5-stage pipeline hazard unit.
- Keeps the E-stage forwarding selects and the load-use stall.
- Replaces the single div-ready stall with an NPEND-entry scoreboard that tracks in-flight long-latency writes (div, mult, multi-cycle load) by tag.
- Produces stallF, stallD, stallE and flushE from the scoreboard, the load-use check and scoreboard-full back-pressure.

Parameters:
REG_AW, 5, register index width (2**REG_AW architectural registers; register 0 never hazards)
NPEND, 4, scoreboard entries (max outstanding long-latency ops, >=2)
TAGW, 2, tag width, must satisfy 2**TAGW >= NPEND

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
rsD  in  REG_AW  D-stage source A index
rtD  in  REG_AW  D-stage source B index
useaD  in  1  D instruction reads rsD
usebD  in  1  D instruction reads rtD
rsE  in  REG_AW  E-stage source A index
rtE  in  REG_AW  E-stage source B index
writeregE  in  REG_AW  E destination
memtoregE  in  1  E is a load
writeregM  in  REG_AW  M destination
regwriteM  in  1  M writes the register file
writeregW  in  REG_AW  W destination
regwriteW  in  1  W writes the register file
iss_valid  in  1  E starts a long-latency op
iss_wreg  in  REG_AW  its destination
iss_ready  out  1  a free entry exists
iss_tag  out  TAGW  entry allocated if the issue is accepted
cmp_valid  in  1  a long-latency op finished (result written this cycle)
cmp_tag  in  TAGW  tag of the finished op
flush_all  in  1  exception/ERET flush
forwardaE  out  2  00 regfile, 10 from M, 01 from W
forwardbE  out  2  same encoding for B
stallF  out  1  hold PC
stallD  out  1  hold IF/ID
stallE  out  1  hold ID/EX
flushE  out  1  bubble into E
sb_count  out  TAGW+1  occupied entries

Behaviour:
- Reset (synchronous, rst high at posedge): all entry valid bits cleared; sb_count=0. Holding rst high forces every output low except iss_ready=1 and iss_tag=0.
- Entry state per index i: valid[i], wreg[i].
- Issue:
  - iss_ready = (sb_count != NPEND), from registered state only. A same-cycle completion does not free an entry for a same-cycle issue.
  - iss_tag = lowest index with valid=0.
  - Accept iff iss_valid & iss_ready & ~flush_all; sets valid/wreg at the next edge.
- Completion: cmp_valid clears valid[cmp_tag] at the next edge. A completion on an invalid tag is ignored (no error, count unchanged).
- Simultaneous issue and completion: both are applied, and sb_count is unchanged. The issue may never reuse the completing tag in that cycle.
- flush_all: clears all entries at the next edge and blocks any issue that cycle. The long-latency unit must drop cancelled ops; later completions for them hit invalid tags and are ignored.
- busy(r) = OR_i(valid[i] & wreg[i]==r) & (r!=0), from registered state. A register is released the cycle after cmp_valid. WAW on the same register is allowed; the register stays busy until every matching entry completes.
- sbstallD = (useaD & busy(rsD)) | (usebD & busy(rtD)).
- lwstallD = memtoregE & writeregE!=0 & ((useaD & writeregE==rsD) | (usebD & writeregE==rtD)).
- fullstallE = iss_valid & ~iss_ready.
- Output priority:
  1. flush_all: all stalls 0, flushE 1.
  2. Else fullstallE: stallF=stallD=stallE=1, flushE=0.
  3. Else sbstallD|lwstallD: stallF=stallD=1, stallE=0, flushE=1.
  4. Else all 0.
- Forwarding (combinational):
  - A: rsE==0 gives 00; else rsE==writeregM & regwriteM gives 10; else rsE==writeregW & regwriteW gives 01; else 00.
  - B: the same rules applied to rtE.
  - M has priority over W.
- No clock-cycle latency on any combinational output. Scoreboard updates take effect one edge later.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds output stall_cycles [31:0], plus sb_stall_cycles [31:0] and full_stall_cycles [31:0].
  - stall_cycles counts cycles with stallD=1.
  - sb_stall_cycles counts cycles where sbstallD causes the stall.
  - full_stall_cycles counts cycles with fullstallE=1.
  - Counters saturate at 32'hFFFFFFFF, clear on rst and are not cleared by flush_all.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Issue iss_wreg=5 (tag 0). Next cycle D has useaD=1, rsD=5 → stallF=stallD=flushE=1 until cmp_valid tag 0. Stall drops the cycle after completion; sb_count goes 1→0.
2. NPEND=4: four issues to regs 1..4 → tags 0,1,2,3 and sb_count=4. A fifth iss_valid → iss_ready=0, stallF=stallD=stallE=1, flushE=0. cmp_tag=2 → the next cycle iss_tag=2 is accepted.
3. Full, with cmp_valid (tag 1) and iss_valid in the same cycle → the issue is not accepted (iss_ready=0) and sb_count goes 4→3. The issue is accepted the next cycle with tag 1.
4. Load-use: memtoregE=1, writeregE=8, rtD=8, usebD=1 → stallD=1, flushE=1. With writeregE=0 → no stall. With usebD=0 → no stall.
5. Forwarding: rsE=rtE=7, writeregM=writeregW=7, both regwrite → forwardaE=forwardbE=10. With regwriteM=0 → 01. With rsE=0 → forwardaE=00.
6. Three entries valid, then flush_all with iss_valid=1 → outputs flushE=1, stalls 0, issue dropped. Next cycle sb_count=0 and cmp_valid for an old tag leaves sb_count=0. rst mid-operation clears the scoreboard the same way.
